// File: rtl/mig_cmd_issuer.sv
// mig_cmd_issuer: pops packed requests from the CPU->DDR command FIFO and issues them to the MIG native app interface.
//   Optional watchdog enabled with `define MIG_ISSUE_TIMEOUT_EN.
//   Ports:
//     clk, rst_n                 ui_clk and asynchronous active-low reset
//     init_calib_complete        no pop until MIG calibration is done
//     rqempty, rdata, rnext      FIFO read side: empty flag, head entry {we, mask, addr, data}, pop pulse
//     app_addr/cmd/en/rdy        MIG command channel (cmd 000 write, 001 read)
//     app_wdf_data/mask/wren/end/rdy  MIG write-data channel (single BL8 beat)
//     app_rd_data_valid/end      read return, used only to release read credits
//     busy                       transaction in flight or reads outstanding
//     timeout_err                sticky watchdog flag (0 when the watchdog is compiled out)
module mig_cmd_issuer #(
    parameter int AW     = 28,
    parameter int DW     = 128,
    parameter int MW     = DW / 8,
    parameter int MAX_RD = 4,
    parameter int FIFODW = 1 + MW + AW + DW,
    parameter int TO_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              rqempty,
    input  logic [FIFODW-1:0] rdata,
    output logic              rnext,
    output logic [AW-1:0]     app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [DW-1:0]     app_wdf_data,
    output logic [MW-1:0]     app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic              app_rd_data_valid,
    input  logic              app_rd_data_end,
    output logic              busy,
    output logic              timeout_err
);
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    state_t          state_q, state_d;
    logic            cmd_done_q, cmd_done_d, dat_done_q, dat_done_d;
    logic [3:0]      rd_cnt_q, rd_cnt_d;
    logic [2:0]      cmd_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [MW-1:0]   mask_q;
    logic            pop, cmd_hs, dat_hs, rd_inc, rd_ret;

    // Writes are never throttled; reads need a free credit.
    assign pop    = state_q == IDLE && init_calib_complete && !rqempty &&
                    (rdata[FIFODW-1] || rd_cnt_q < 4'(MAX_RD));
    assign cmd_hs = app_en && app_rdy;
    assign dat_hs = app_wdf_wren && app_wdf_rdy;
    assign rd_inc = state_q == RD && app_rdy;
    assign rd_ret = app_rd_data_valid && app_rd_data_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_done_q <= 1'b0;
            dat_done_q <= 1'b0;
            rd_cnt_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            cmd_done_q <= cmd_done_d;
            dat_done_q <= dat_done_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= 3'b000;
            addr_q <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else if (pop) begin
            cmd_q  <= {2'b00, ~rdata[FIFODW-1]};
            mask_q <= rdata[DW+AW+:MW];
            addr_q <= rdata[DW+:AW];
            data_q <= rdata[DW-1:0];
        end
    end

    // Command and data channels of a write complete independently, in either order.
    always_comb begin
        state_d    = state_q;
        cmd_done_d = cmd_done_q;
        dat_done_d = dat_done_q;
        case (state_q)
            IDLE: if (pop) state_d = rdata[FIFODW-1] ? WR : RD;
            WR: begin
                cmd_done_d = cmd_done_q || cmd_hs;
                dat_done_d = dat_done_q || dat_hs;
                if (cmd_done_d && dat_done_d) begin
                    state_d    = IDLE;
                    cmd_done_d = 1'b0;
                    dat_done_d = 1'b0;
                end
            end
            RD: if (cmd_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rnext        = pop;
        app_en       = (state_q == WR && !cmd_done_q) || state_q == RD;
        app_wdf_wren = state_q == WR && !dat_done_q;
    end

    // Issue and return in the same cycle cancel; a return with no credit outstanding is dropped.
    assign rd_cnt_d = (rd_inc && !rd_ret) ? rd_cnt_q + 4'd1 :
                      (rd_ret && !rd_inc && rd_cnt_q != 4'd0) ? rd_cnt_q - 4'd1 : rd_cnt_q;

    assign app_cmd      = cmd_q;
    assign app_addr     = addr_q;
    assign app_wdf_data = data_q;
    assign app_wdf_mask = mask_q;
    assign app_wdf_end  = app_wdf_wren;
    assign busy         = state_q != IDLE || rd_cnt_q != 4'd0;

`ifdef MIG_ISSUE_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        to_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            to_q   <= 1'b0;
        end else begin
            wdog_q <= state_q == IDLE ? 16'd0 : wdog_q + 16'(wdog_q != 16'hFFFF);
            if (state_q != IDLE && wdog_q == 16'(TO_CYC - 1)) to_q <= 1'b1;
        end
    end
    assign timeout_err = to_q;
`else
    assign timeout_err = 1'b0 & (TO_CYC == 0);
`endif
endmodule

// File: tb/tb_mig_cmd_issuer.sv
// tb_mig_cmd_issuer: directed bench with a FIFO model and command/write-data scoreboards for mig_cmd_issuer.
module tb_mig_cmd_issuer;
    localparam int AW = 28, DW = 128, MW = 16, MAX_RD = 4, FIFODW = 1 + MW + AW + DW;

    logic              clk = 1'b0;
    logic              rst_n, calib, rqempty, rnext, app_en, app_rdy;
    logic              app_wdf_wren, app_wdf_end, app_wdf_rdy, rdv, rde, busy, timeout_err;
    logic [FIFODW-1:0] rdata;
    logic [AW-1:0]     app_addr;
    logic [2:0]        app_cmd;
    logic [DW-1:0]     app_wdf_data;
    logic [MW-1:0]     app_wdf_mask;

    logic [FIFODW-1:0] fq[$];
    logic [AW+2:0]     cq[$];
    logic [MW+DW-1:0]  wq[$];
    int checks = 0, errors = 0, pops = 0, rd_cmds = 0;
    logic pop_pend = 1'b0, prev_rn = 1'b0;

    always #5 clk = ~clk;

    mig_cmd_issuer #(.AW(AW), .DW(DW), .MW(MW), .MAX_RD(MAX_RD), .FIFODW(FIFODW), .TO_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .init_calib_complete(calib), .rqempty(rqempty), .rdata(rdata),
        .rnext(rnext), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(rdv),
        .app_rd_data_end(rde), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        rqempty = fq.size() == 0;
        rdata   = fq.size() != 0 ? fq[0] : '0;
    endtask

    task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        fq.push_back({we, m, a, d});
        cq.push_back({2'b00, ~we, a});
        if (we) wq.push_back({m, d});
        upd();
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ret();
        rdv = 1'b1; rde = 1'b1;
        cyc(1);
        rdv = 1'b0; rde = 1'b0;
        cyc(4);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            pop_pend = rnext;
            if (rnext) begin
                pops++;
                chk("rnext_gap", prev_rn, 1'b0);
            end
            prev_rn = rnext;
            if (app_en && app_rdy) begin
                if (app_cmd == 3'b001) rd_cmds++;
                chk("cmd_q_nonempty", cq.size() != 0, 1'b1);
                if (cq.size() != 0) chk("cmd_addr", {app_cmd, app_addr}, cq.pop_front());
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                chk("wdf_end", app_wdf_end, 1'b1);
                chk("wdf_q_nonempty", wq.size() != 0, 1'b1);
                if (wq.size() != 0) chk("wdf_data_mask", {app_wdf_mask, app_wdf_data}, wq.pop_front());
            end
        end else begin
            pop_pend = 1'b0;
            prev_rn  = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (pop_pend) begin
            #1;
            if (fq.size() != 0) void'(fq.pop_front());
            upd();
        end
    end

    initial begin
        rst_n = 1'b0; calib = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1; rdv = 1'b0; rde = 1'b0;
        upd();
        push(1'b1, 28'h0000100, {16{8'hA5}}, 16'h0000);
        cyc(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rnext", rnext, 1'b0);
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_wren", app_wdf_wren, 1'b0);
        chk("rst_cmd", app_cmd, 3'b000);
        chk("rst_addr", app_addr, 28'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);
        cyc(4);
        chk("no_pop_before_calib", pops, 0);
        chk("no_cmd_before_calib", app_en, 1'b0);
        calib = 1'b1;
        @(negedge clk);
        chk("rnext_pulse", rnext, 1'b1);
        @(negedge clk);
        chk("rnext_single", rnext, 1'b0);
        chk("wr_app_en", app_en, 1'b1);
        chk("wr_wren", app_wdf_wren, 1'b1);
        chk("wr_cmd", app_cmd, 3'b000);
        chk("wr_addr", app_addr, 28'h0000100);
        chk("wr_busy", busy, 1'b1);
        @(negedge clk);
        chk("wr_done_en", app_en, 1'b0);
        chk("wr_done_wren", app_wdf_wren, 1'b0);
        chk("wr_done_idle", busy, 1'b0);

        // command stalled five cycles, data accepted at once
        cyc(1);
        app_rdy = 1'b0;
        push(1'b1, 28'h0002000, {4{32'hDEADBEEF}}, 16'h00F0);
        @(negedge clk);
        chk("stall_pop", rnext, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_app_en", app_en, 1'b1);
            chk("stall_addr", app_addr, 28'h0002000);
            chk("stall_wren", app_wdf_wren, i == 0);
            if (i == 4) begin
                cyc(1);
                app_rdy = 1'b1;
            end
        end
        @(negedge clk);
        chk("stall_end_en", app_en, 1'b0);
        chk("stall_end_busy", busy, 1'b0);
        chk("stall_one_pop", pops, 2);

        // data stalled, command accepted at once
        cyc(1);
        app_wdf_rdy = 1'b0;
        push(1'b1, 28'h0003000, {8{16'h1234}}, 16'h8001);
        @(negedge clk);
        chk("dstall_pop", rnext, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dstall_wren", app_wdf_wren, 1'b1);
            chk("dstall_app_en", app_en, i == 0);
            chk("dstall_data", app_wdf_data, {8{16'h1234}});
            if (i == 2) begin
                cyc(1);
                app_wdf_rdy = 1'b1;
            end
        end
        @(negedge clk);
        chk("dstall_end_wren", app_wdf_wren, 1'b0);
        chk("dstall_end_busy", busy, 1'b0);
        chk("dstall_pops", pops, 3);

        // read credit limit
        cyc(1);
        for (int i = 0; i < 6; i++) push(1'b0, 28'(32'h0100000 + i * 8), '0, '0);
        cyc(20);
        chk("rd_limit", rd_cmds, 4);
        chk("rd_limit_busy", busy, 1'b1);
        chk("rd_limit_rnext", rnext, 1'b0);
        chk("rd_limit_fifo", fq.size(), 2);
        rdv = 1'b1;
        cyc(1);
        rdv = 1'b0;
        cyc(6);
        chk("rd_valid_no_end", rd_cmds, 4);
        ret();
        cyc(2);
        chk("rd_fifth", rd_cmds, 5);
        chk("rd_fifth_fifo", fq.size(), 1);
        repeat (5) ret();
        chk("rd_drain_cmds", rd_cmds, 6);
        chk("rd_drain_busy", busy, 1'b0);

        // coincident issue and return at rd_cnt=2
        push(1'b0, 28'h0200000, '0, '0);
        push(1'b0, 28'h0200008, '0, '0);
        cyc(8);
        chk("co_two_reads", rd_cmds, 8);
        app_rdy = 1'b0;
        push(1'b0, 28'h0200010, '0, '0);
        cyc(3);
        chk("co_rd_waiting", app_en, 1'b1);
        app_rdy = 1'b1; rdv = 1'b1; rde = 1'b1;
        cyc(1);
        rdv = 1'b0; rde = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b0, 28'(32'h0200018 + i * 8), '0, '0);
        cyc(14);
        chk("co_credit_two", rd_cmds, 11);
        chk("co_fifo_left", fq.size(), 2);
        repeat (6) ret();
        chk("co_drain_cmds", rd_cmds, 13);
        chk("co_drain_busy", busy, 1'b0);

        // spurious returns at rd_cnt=0
        repeat (2) ret();
        for (int i = 0; i < 5; i++) push(1'b0, 28'(32'h0300000 + i * 8), '0, '0);
        cyc(14);
        chk("sat_zero_limit", rd_cmds, 17);
        chk("sat_zero_fifo", fq.size(), 1);
        repeat (5) ret();
        chk("sat_drain_cmds", rd_cmds, 18);
        chk("sat_drain_busy", busy, 1'b0);

        // watchdog on a stuck read
        app_rdy = 1'b0;
        push(1'b0, 28'h0400000, '0, '0);
        cyc(20);
        chk("to_busy", busy, 1'b1);
`ifdef MIG_ISSUE_TIMEOUT_EN
        chk("to_set", timeout_err, 1'b1);
`else
        chk("to_absent", timeout_err, 1'b0);
`endif
        app_rdy = 1'b1;
        cyc(3);
        chk("to_rd_issued", rd_cmds, 19);
`ifdef MIG_ISSUE_TIMEOUT_EN
        chk("to_sticky", timeout_err, 1'b1);
`else
        chk("to_absent_after", timeout_err, 1'b0);
`endif

        // reset mid-transaction
        app_rdy = 1'b0;
        push(1'b1, 28'h0500000, {4{32'hCAFEF00D}}, 16'h0F0F);
        cyc(3);
        chk("mid_rst_pre_en", app_en, 1'b1);
        rst_n = 1'b0;
        fq.delete(); cq.delete(); wq.delete();
        upd();
        #1;
        chk("mid_rst_app_en", app_en, 1'b0);
        chk("mid_rst_wren", app_wdf_wren, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_addr", app_addr, 28'h0);
        chk("mid_rst_timeout", timeout_err, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        app_rdy = 1'b1;
        cyc(3);
        chk("post_rst_idle", busy, 1'b0);
        chk("post_rst_rnext", rnext, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
